id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
- Parametrised decode→execute pipeline register carrying operands, immediate, PC, ALU/opcode info and writeback control.
- Adds what the previous stage register lacked:
  - valid/ready handshake in both directions
  - stall, and flush with priority over stall
  - bubble insertion
  - write-enable qualification
  - optional 2-entry skid buffer that cuts the combinational ready path.
- Sits between the decode unit and the ALU/execute stage.

Parameters:
XLEN, 64, width of operand, immediate and PC fields
ALU_W, 10, width of ALU operation info
OPC_W, 2, width of opcode class info
RD_W, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  decode presents a valid instruction
in_ready  out  1  register can accept this cycle
in_pc  in  XLEN  instruction PC
in_imm  in  XLEN  decoded immediate
in_rs1_data  in  XLEN  source operand 1
in_rs2_data  in  XLEN  source operand 2
in_alu_info  in  ALU_W  ALU operation info
in_opcode_info  in  OPC_W  opcode class info
in_rd  in  RD_W  destination register
in_reg_wen  in  1  register write enable
stall  in  1  hazard hold from hazard unit
flush  in  1  kill all held/incoming instructions (branch redirect)
out_valid  out  1  execute stage has a valid instruction
out_ready  in  1  execute stage accepts
out_pc, out_imm, out_rs1_data, out_rs2_data  out  XLEN  registered payload
out_alu_info  out  ALU_W; out_opcode_info  out  OPC_W; out_rd  out  RD_W
out_reg_wen  out  1  qualified write enable

Behaviour:
- Reset (async, rst=1): every output register 0, including out_imm and out_pc; out_valid=0. in_ready is 0 while rst is high and 1 from the first cycle after release.
- Accept: transfer when in_valid & in_ready. Payload appears on out_* one cycle later (latency 1) with out_valid=1.
- Hold: out_valid & ~out_ready keeps every out_* stable, bit-exact, until accepted.
- Drain: out_valid & out_ready with no new accept → out_valid=0 next cycle. Payload is retained, not zeroed.
- Base mode ready: in_ready = ~stall & ~flush & (~out_valid | out_ready), combinational.
- Stall: stall=1 → no accept. The held entry may still drain if out_ready=1; this creates a bubble (out_valid=0).
- Flush (priority over stall and accept): out_valid=0 and skid cleared next cycle; the incoming instruction is discarded.
- Flush and in_valid in the same cycle → nothing captured.
- Flush: out_reg_wen=0 next cycle. Other payload fields are don't-care but held.
- Write-enable qualification: out_reg_wen = captured in_reg_wen & (in_rd != 0). This is evaluated at capture and never set for x0.
- Invariant: out_reg_wen is 0 whenever out_valid=0 after a flush or reset.
- Widths: all fields pass through unmodified. No sign extension is done here.

Optional Feature:
- Macro: ID_EX_SKID_BUF_EN.
- Defined:
  - A second (skid) entry is added.
  - in_ready = ~skid_valid & ~stall & ~flush, and is a pure register output (no out_ready in its path).
  - Main full, out_ready=0, accept → entry goes to skid, in_ready=0 next cycle.
  - Main accepted while skid full → skid moves to main next cycle, skid empties, in_ready=1.
  - Ordering is strictly FIFO.
  - Flush clears both entries.
- Undefined: single entry, combinational in_ready as above, no skid storage synthesised.

Decomposition:
- Shared package cpu_pipe_pkg:
  - idex_payload_t struct (pc, imm, rs1, rs2, alu_info, opcode_info, rd, reg_wen)
  - XLEN/ALU_W/OPC_W/RD_W defaults
  - RD_ZERO constant.
- One sub-module, pipe_payload_slot: a payload register with load enable and async reset. It is instanced once for main and once for skid.

Test Plan:
- Reset: rst=1 mid-run with out_valid=1 → outputs 0 immediately (async), out_valid=0. First accept after release: in_pc=0x80000000 → out_pc=0x80000000 next cycle.
- Backpressure: accept imm=0x10 then, with out_ready=0 for 3 cycles, offer imm=0x20 → out_imm stays 0x10. With skid enabled, 0x20 then appears after the first out_ready=1, in order.
- Stall: stall=1 with out_ready=1 and in_valid=1 → in_ready=0, one bubble (out_valid=0). Deassert → next instruction captured.
- Flush: flush=1 with both entries full and in_valid=1 → next cycle out_valid=0, out_reg_wen=0. No discarded PC ever appears on out_pc with out_valid=1.
- x0 write: in_rd=0, in_reg_wen=1 → out_reg_wen=0. in_rd=5, in_reg_wen=1 → out_reg_wen=1.
- Throughput: 8 back-to-back instructions with out_ready=1 and no stall → 8 consecutive out_valid cycles with PCs 0x0,0x4,…,0x1C.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pipe_pkg
//   Shared definitions for the CPU pipeline stage registers.
//   - XLEN_DEF / ALU_W_DEF / OPC_W_DEF / RD_W_DEF : default field widths
//   - RD_ZERO        : index of the hard-wired zero register (x0)
//   - idex_payload_t : decode->execute payload at the default widths
// -----------------------------------------------------------------------------
package cpu_pipe_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int ALU_W_DEF = 10;
    localparam int OPC_W_DEF = 2;
    localparam int RD_W_DEF  = 5;

    localparam logic [RD_W_DEF-1:0] RD_ZERO = '0;

    typedef struct packed {
        logic [XLEN_DEF-1:0]  pc;
        logic [XLEN_DEF-1:0]  imm;
        logic [XLEN_DEF-1:0]  rs1;
        logic [XLEN_DEF-1:0]  rs2;
        logic [ALU_W_DEF-1:0] alu_info;
        logic [OPC_W_DEF-1:0] opcode_info;
        logic [RD_W_DEF-1:0]  rd;
        logic                 reg_wen;
    } idex_payload_t;

endpackage

// File: rtl/pipe_payload_slot.sv
// -----------------------------------------------------------------------------
// pipe_payload_slot
//   One payload storage entry of a pipeline register: loads d when load=1,
//   otherwise holds. Cleared to zero by the asynchronous reset.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous, active-high reset
//     load - capture enable
//     d    - payload to capture (W bits)
//     q    - stored payload (W bits)
// -----------------------------------------------------------------------------
module pipe_payload_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
//   Decode -> execute pipeline register with valid/ready handshake on both
//   sides, hazard stall, branch flush (flush beats stall and accept), and
//   write-enable qualification (writes to x0 are never marked enabled).
//
//   Optional build macro ID_EX_SKID_BUF_EN:
//     defined   - adds a second (skid) entry so that in_ready is a registered
//                 signal with no path from out_ready; entries leave in FIFO
//                 order and flush clears both.
//     undefined - single entry, in_ready derived combinationally from
//                 out_ready.
//
//   Ports:
//     clk, rst                  - clock (rising edge), async active-high reset
//     in_valid / in_ready       - upstream handshake from decode
//     in_pc, in_imm,
//     in_rs1_data, in_rs2_data  - XLEN-bit payload fields
//     in_alu_info, in_opcode_info, in_rd, in_reg_wen - control payload
//     stall                     - hazard hold, blocks accept
//     flush                     - kills held and incoming instructions
//     out_valid / out_ready     - downstream handshake to execute
//     out_*                     - registered payload, out_reg_wen qualified
// -----------------------------------------------------------------------------
module id_ex_pipe_reg
    import cpu_pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int ALU_W = ALU_W_DEF,
    parameter int OPC_W = OPC_W_DEF,
    parameter int RD_W  = RD_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [ALU_W-1:0] in_alu_info,
    input  logic [OPC_W-1:0] in_opcode_info,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_reg_wen,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_rs1_data,
    output logic [XLEN-1:0]  out_rs2_data,
    output logic [ALU_W-1:0] out_alu_info,
    output logic [OPC_W-1:0] out_opcode_info,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_reg_wen
);

    // Payload at this instance's widths (the package type fixes the defaults).
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [ALU_W-1:0] alu_info;
        logic [OPC_W-1:0] opcode_info;
        logic [RD_W-1:0]  rd;
        logic             reg_wen;
    } payload_t;

    localparam int PAY_W = $bits(payload_t);

    // Write enable is qualified once, at capture, so x0 can never be written.
    function automatic logic qual_wen(input logic wen, input logic [RD_W-1:0] rd);
        return wen & (rd != RD_W'(RD_ZERO));
    endfunction

    payload_t in_pay;
    payload_t pay_p1;
    payload_t flushed_p1;
    payload_t main_d;
    logic     main_load;
    logic     vld_p1;
    logic     accept;
    logic     main_free;

    // ---- stage p0: incoming payload and handshake ----
    assign in_pay = '{
        pc:          in_pc,
        imm:         in_imm,
        rs1:         in_rs1_data,
        rs2:         in_rs2_data,
        alu_info:    in_alu_info,
        opcode_info: in_opcode_info,
        rd:          in_rd,
        reg_wen:     qual_wen(in_reg_wen, in_rd)
    };

    // On flush the main entry is reloaded with itself minus the write enable,
    // so other fields stay put while the killed slot can never write back.
    always_comb begin
        flushed_p1         = pay_p1;
        flushed_p1.reg_wen = 1'b0;
    end

    assign main_free = ~vld_p1 | out_ready;
    assign accept    = in_valid & in_ready;

`ifdef ID_EX_SKID_BUF_EN
    payload_t pay_skid;
    logic     skid_vld;
    logic     skid_load;
    logic     ready_q;

    // ready_q mirrors ~skid_vld but is held low during reset.
    assign in_ready = ready_q & ~stall & ~flush;

    always_comb begin
        main_load = 1'b0;
        main_d    = in_pay;
        skid_load = 1'b0;
        if (flush) begin
            main_load = 1'b1;
            main_d    = flushed_p1;
        end else if (main_free && skid_vld) begin
            main_load = 1'b1;
            main_d    = pay_skid;
        end else if (accept && main_free) begin
            main_load = 1'b1;
        end else if (accept) begin
            skid_load = 1'b1;
        end
    end

    // ---- stage p1: main/skid occupancy ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            skid_vld <= 1'b0;
            ready_q  <= 1'b0;
        end else if (flush) begin
            vld_p1   <= 1'b0;
            skid_vld <= 1'b0;
            ready_q  <= 1'b1;
        end else if (main_free) begin
            // A full skid implies in_ready was low, so accept and a skid
            // refill cannot coincide here.
            vld_p1   <= skid_vld | accept;
            skid_vld <= 1'b0;
            ready_q  <= 1'b1;
        end else if (accept) begin
            skid_vld <= 1'b1;
            ready_q  <= 1'b0;
        end
    end

    pipe_payload_slot #(.W(PAY_W)) u_skid_slot (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_pay),
        .q    (pay_skid)
    );
`else
    assign in_ready = ~rst & ~stall & ~flush & main_free;

    always_comb begin
        main_load = flush | accept;
        main_d    = flush ? flushed_p1 : in_pay;
    end

    // ---- stage p1: main occupancy ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end
`endif

    pipe_payload_slot #(.W(PAY_W)) u_main_slot (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (pay_p1)
    );

    // ---- stage p1 outputs ----
    assign out_valid       = vld_p1;
    assign out_pc          = pay_p1.pc;
    assign out_imm         = pay_p1.imm;
    assign out_rs1_data    = pay_p1.rs1;
    assign out_rs2_data    = pay_p1.rs2;
    assign out_alu_info    = pay_p1.alu_info;
    assign out_opcode_info = pay_p1.opcode_info;
    assign out_rd          = pay_p1.rd;
    assign out_reg_wen     = pay_p1.reg_wen;

endmodule
